// File: rtl/memoria_pkg.sv
// Shared defaults and FSM encoding for the memoria command master.
package memoria_pkg;
   localparam int AW_DEF = 5;
   localparam int DW_DEF = 14;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;
endpackage

// File: rtl/memoria_master.sv
// Command master driving a single-port memoria array, one beat at a time.
// Define MEMORIA_MASTER_BURST_EN to add req_len and 1-4 beat commands.
module memoria_master
   import memoria_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wr,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_data,
`ifdef MEMORIA_MASTER_BURST_EN
   input  logic [1:0]    req_len,
`endif
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic [AW-1:0] rsp_addr,
   output logic          done,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_datain,
   input  logic [DW-1:0] mem_dataout
);

   state_t        r_state;
   state_t        w_next;
   logic          r_wr;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic [1:0]    r_cnt;
   logic          r_rsp_valid;
   logic [DW-1:0] r_rsp_data;
   logic [AW-1:0] r_rsp_addr;
   logic [1:0]    w_len;
   logic          w_last;
   logic          w_accept;
   logic          w_step;

`ifdef MEMORIA_MASTER_BURST_EN
   assign w_len = req_len;
`else
   assign w_len = 2'd0;
`endif

   assign w_last   = (r_cnt == 2'd0);
   assign w_accept = req_valid & req_ready;
   // Advance to the next beat after a write issue or a read capture.
   assign w_step   = !w_last &&
                     ((r_state == ISSUE && r_wr) ||
                      (r_state == CAPTURE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = ISSUE;
         end
         ISSUE: begin
            mem_en = 1'b1;
            mem_wr = r_wr;
            if (!r_wr)       w_next = CAPTURE;
            else if (w_last) w_next = DONE;
         end
         CAPTURE: begin
            w_next = w_last ? DONE : ISSUE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_cnt       <= 2'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_addr  <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_accept) begin
            r_wr   <= req_wr;
            r_addr <= req_addr;
            r_data <= req_data;
            r_cnt  <= w_len;
         end
         if (w_step) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
         end
         if (r_state == CAPTURE) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= mem_dataout;
            r_rsp_addr  <= r_addr;
         end
      end
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign rsp_addr    = r_rsp_addr;
   assign mem_address = r_addr;
   assign mem_datain  = r_data;

endmodule

// File: tb/tb_memoria_master.sv
// Self-checking bench for memoria_master: behavioural timeline model,
// a memory stub, directed cases and randomized command traffic.
module tb_memoria_master;

   localparam int AW = 5;
   localparam int DW = 14;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic [1:0]    req_len;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] rsp_addr;
   logic          done;
   logic          mem_en;
   logic          mem_wr;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_datain;
   logic [DW-1:0] mem_dataout;

   memoria_master #(.AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_data    (req_data),
`ifdef MEMORIA_MASTER_BURST_EN
      .req_len     (req_len),
`endif
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_addr    (rsp_addr),
      .done        (done),
      .mem_en      (mem_en),
      .mem_wr      (mem_wr),
      .mem_address (mem_address),
      .mem_datain  (mem_datain),
      .mem_dataout (mem_dataout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory stub: synchronous write, registered read
   logic [DW-1:0] smem [32];
   initial begin
      for (int i = 0; i < 32; i++) smem[i] = '0;
      mem_dataout = '0;
   end
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) smem[mem_address] <= mem_datain;
         else        mem_dataout <= smem[mem_address];
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    name, act, exp, $time);
   endfunction

   // behavioural model: per-period expectations keyed by period index
   typedef struct packed {
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } en_t;
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } rsp_t;

   en_t           en_q  [int];
   rsp_t          rsp_q [int];
   bit            dn_q  [int];
   logic [DW-1:0] mdl   [32];
   int            edge_cnt  = 0;
   int            idle_from = 0;

   initial for (int i = 0; i < 32; i++) mdl[i] = '0;

   function automatic void model_clear();
      en_q.delete();
      rsp_q.delete();
      dn_q.delete();
      idle_from = 0;
   endfunction

   function automatic void schedule(int n);
      int b;
      logic [AW-1:0] a;
`ifdef MEMORIA_MASTER_BURST_EN
      b = int'(req_len) + 1;
`else
      b = 1;
`endif
      if (req_wr) begin
         for (int k = 0; k < b; k++) begin
            a = req_addr + AW'(k);
            en_q[n + k] = '{1'b1, a, req_data};
         end
         dn_q[n + b] = 1'b1;
         idle_from   = n + b + 1;
      end else begin
         for (int k = 0; k < b; k++) begin
            a = req_addr + AW'(k);
            en_q[n + 2*k]      = '{1'b0, a, req_data};
            rsp_q[n + 2*k + 2] = '{a, mdl[a]};
         end
         dn_q[n + 2*b] = 1'b1;
         idle_from     = n + 2*b + 1;
      end
   endfunction

   always @(negedge rst_n) model_clear();

   always @(posedge clk) begin
      if (!rst_n) begin
         model_clear();
      end else begin
         if (en_q.exists(edge_cnt) && en_q[edge_cnt].wr)
            mdl[en_q[edge_cnt].a] = en_q[edge_cnt].d;
         if (req_valid && edge_cnt >= idle_from)
            schedule(edge_cnt + 1);
      end
      edge_cnt++;
   end

   // compare process plus event monitors
   int rsp_cnt = 0;
   int done_cnt = 0;
   int en_cnt = 0;
   int last_rd_en_p = 0;
   int last_rsp_p = 0;
   logic [DW-1:0] last_rsp_data;
   logic [AW-1:0] last_rsp_addr;

   always @(negedge clk) begin
      int p;
      p = edge_cnt;
      if (!rst_n) begin
         chk("rst_ready", 32'(req_ready), 32'd1);
         chk("rst_ctl", 32'({mem_en, mem_wr, rsp_valid, done}), 32'd0);
         chk("rst_mem", 32'({mem_address, mem_datain}), 32'd0);
         chk("rst_rsp", 32'({rsp_addr, rsp_data}), 32'd0);
      end else begin
         chk("req_ready", 32'(req_ready), 32'(p >= idle_from));
         chk("mem_en", 32'(mem_en), 32'(en_q.exists(p)));
         if (en_q.exists(p)) begin
            chk("mem_wr", 32'(mem_wr), 32'(en_q[p].wr));
            chk("mem_address", 32'(mem_address), 32'(en_q[p].a));
            chk("mem_datain", 32'(mem_datain), 32'(en_q[p].d));
         end
         chk("rsp_valid", 32'(rsp_valid), 32'(rsp_q.exists(p)));
         if (rsp_q.exists(p)) begin
            chk("rsp_addr", 32'(rsp_addr), 32'(rsp_q[p].a));
            chk("rsp_data", 32'(rsp_data), 32'(rsp_q[p].d));
         end
         chk("done", 32'(done), 32'(dn_q.exists(p)));
      end
      if (mem_en) en_cnt++;
      if (mem_en && !mem_wr) last_rd_en_p = p;
      if (rsp_valid) begin
         rsp_cnt++;
         last_rsp_p    = p;
         last_rsp_data = rsp_data;
         last_rsp_addr = rsp_addr;
      end
      if (done) done_cnt++;
   end

   // hold=1 keeps the same command presented with valid high while busy
   task automatic do_cmd(input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] len,
                         input bit hold);
      int t;
      @(negedge clk); #1;
      req_wr = wr; req_addr = a; req_data = d; req_len = len;
      req_valid = 1'b1;
      t = 0;
      while (!req_ready && t < 40) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 40) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(negedge clk); #1;
      t = 0;
      while (!req_ready && t < 40) begin
         if (!hold) begin
            req_valid = 1'($urandom);
            req_wr    = 1'($urandom);
            req_addr  = AW'($urandom);
            req_data  = DW'($urandom);
            req_len   = 2'($urandom);
         end
         @(negedge clk); #1; t++;
      end
      req_valid = 1'b0;
      if (t >= 40) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int d0, r0, e0, rdly;
      logic [1:0] rlen;
      rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
      req_addr = '0; req_data = '0; req_len = 2'd0;
      #1;
      chk("por_ready", 32'(req_ready), 32'd1);
      chk("por_mem_en", 32'(mem_en), 32'd0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // write 0x3FFF @4 then read it back
      d0 = done_cnt;
      do_cmd(1'b1, 5'd4, 14'h3FFF, 2'd0, 1'b0);
      do_cmd(1'b0, 5'd4, 14'h0000, 2'd0, 1'b0);
      chk("d4_data", 32'(last_rsp_data), 32'h3FFF);
      chk("d4_addr", 32'(last_rsp_addr), 32'd4);
      chk("d4_latency", 32'(last_rsp_p - last_rd_en_p), 32'd2);
      chk("d4_done_cnt", 32'(done_cnt - d0), 32'd2);

      // write 0x0155 @2, read with valid held high throughout
      do_cmd(1'b1, 5'd2, 14'h0155, 2'd0, 1'b0);
      e0 = en_cnt; d0 = done_cnt; r0 = rsp_cnt;
      do_cmd(1'b0, 5'd2, 14'h0000, 2'd0, 1'b1);
      chk("d2_en_cnt", 32'(en_cnt - e0), 32'd1);
      chk("d2_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
      chk("d2_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("d2_data", 32'(last_rsp_data), 32'h0155);

      // top address boundary
      do_cmd(1'b1, 5'd31, 14'h1234, 2'd0, 1'b0);
      do_cmd(1'b0, 5'd31, 14'h0000, 2'd0, 1'b0);
      chk("d31_data", 32'(last_rsp_data), 32'h1234);
      chk("d31_addr", 32'(last_rsp_addr), 32'd31);

`ifdef MEMORIA_MASTER_BURST_EN
      do_cmd(1'b1, 5'd30, 14'h0030, 2'd0, 1'b0);
      do_cmd(1'b1, 5'd0,  14'h0100, 2'd0, 1'b0);
      do_cmd(1'b1, 5'd1,  14'h0101, 2'd0, 1'b0);
      r0 = rsp_cnt; d0 = done_cnt;
      do_cmd(1'b0, 5'd30, 14'h0000, 2'd3, 1'b0);
      chk("b_rsp_cnt", 32'(rsp_cnt - r0), 32'd4);
      chk("b_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("b_last_addr", 32'(last_rsp_addr), 32'd1);
      chk("b_last_data", 32'(last_rsp_data), 32'h0101);
      e0 = en_cnt;
      do_cmd(1'b1, 5'd7, 14'h0AAA, 2'd2, 1'b0);
      chk("bw_en_cnt", 32'(en_cnt - e0), 32'd3);
      for (int k = 7; k <= 9; k++) begin
         do_cmd(1'b0, AW'(k), 14'h0000, 2'd0, 1'b0);
         chk("bw_readback", 32'(last_rsp_data), 32'h0AAA);
      end
      rlen = 2'd3; rdly = 2;
`else
      rlen = 2'd0; rdly = 1;
`endif

      // reset in the middle of a read
      @(negedge clk); #1;
      req_wr = 1'b0; req_addr = 5'd9; req_len = rlen; req_valid = 1'b1;
      @(negedge clk); #1;
      req_valid = 1'b0;
      repeat (rdly) @(negedge clk);
      #1;
      r0 = rsp_cnt; d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("abort_mem_en", 32'(mem_en), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_rsp_cnt", 32'(rsp_cnt - r0), 32'd0);
      chk("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
      d0 = done_cnt;
      do_cmd(1'b1, 5'd12, 14'h2222, 2'd0, 1'b0);
      do_cmd(1'b0, 5'd12, 14'h0000, 2'd0, 1'b0);
      chk("post_abort_data", 32'(last_rsp_data), 32'h2222);
      chk("post_abort_done", 32'(done_cnt - d0), 32'd2);

      // randomized traffic
      for (int i = 0; i < 80; i++) begin
         do_cmd(1'($urandom), AW'($urandom), DW'($urandom),
                2'($urandom), 1'($urandom_range(0, 3) == 0));
      end

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
